// File: rtl/pa_soc_dbus_arb_pkg.sv
// Shared types and widths for the two-master data-bus arbiter.
package pa_soc_dbus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int LAT_CNT_W  = 3;
  localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/pa_soc_dbus_arb_rr.sv
// Two-way round-robin picker with bounded lock retention; owns the priority
// pointer and the consecutive-retained-grant counter.
module pa_soc_arb_rr
  import pa_soc_dbus_arb_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic       done,
  input  logic       winner,
  output logic [1:0] pick
);

  logic                  ptr;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic                  other;
  logic                  retain;

  assign other  = ~winner;
  assign retain = lock[winner] & req[winner] & (lock_cnt < LOCK_CNT_W'(LOCK_MAX));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b0;
      lock_cnt <= '0;
    end else if (done) begin
      if (retain) begin
        ptr      <= winner;
        lock_cnt <= req[other] ? lock_cnt + LOCK_CNT_W'(1) : '0;
      end else begin
        ptr      <= other;
        lock_cnt <= '0;
      end
    end
  end

  // NOTE: pick gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = ptr ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/pa_soc_dbus_arb.sv
// Shares the single slave data path between the core data port (m0) and a
// second master (m1): one slave strobe per request, read wait states, ready pulse.
module pa_soc_dbus_arb
  import pa_soc_dbus_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_lock_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_rd_i,
  input  logic              m0_we_i,
  input  logic [2:0]        m0_size_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ready_o,
  input  logic              m1_req_i,
  input  logic              m1_lock_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_rd_i,
  input  logic              m1_we_i,
  input  logic [2:0]        m1_size_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ready_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic              s_rd_o,
  output logic              s_we_o,
  output logic [2:0]        s_size_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic [1:0]        gnt_o
);

  arb_state_e            state, state_nxt;
  logic                  win;   // 0 = m0, 1 = m1
  logic                  rd_q;  // a true read: rd without we
  logic                  we_q;
  logic [LAT_CNT_W-1:0]  lat_cnt;
  logic                  lat_last;
  logic [1:0]            pick;
  logic                  take;

  assign take     = (state == ST_IDLE) && (pick != 2'b00);
  assign lat_last = (lat_cnt == LAT_CNT_W'(RD_LAT - 1));

  pa_soc_arb_rr #(.LOCK_MAX(LOCK_MAX)) u_rr (
    .clk    (clk_i),
    .rst    (rst_i),
    .req    ({m1_req_i, m0_req_i}),
    .lock   ({m1_lock_i, m0_lock_i}),
    .done   (state == ST_DONE),
    .winner (win),
    .pick   (pick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (take) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = rd_q ? ST_WAIT : ST_DONE;
      ST_WAIT:  if (lat_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the field and read-data registers drive ports that must read 0 in
  // reset, so they are reset like control state rather than left free-running.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win       <= 1'b0;
      rd_q      <= 1'b0;
      we_q      <= 1'b0;
      s_addr_o  <= '0;
      s_size_o  <= '0;
      s_data_o  <= '0;
      lat_cnt   <= '0;
      m0_data_o <= '0;
      m1_data_o <= '0;
    end else begin
      if (take) begin
        win <= pick[1];
        if (pick[1]) begin
          s_addr_o <= m1_addr_i;
          s_size_o <= m1_size_i;
          s_data_o <= m1_data_i;
          rd_q     <= m1_rd_i & ~m1_we_i;
          we_q     <= m1_we_i;
        end else begin
          s_addr_o <= m0_addr_i;
          s_size_o <= m0_size_i;
          s_data_o <= m0_data_i;
          rd_q     <= m0_rd_i & ~m0_we_i;
          we_q     <= m0_we_i;
        end
      end
      if (state == ST_ISSUE) begin
        lat_cnt <= '0;
      end else if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt + LAT_CNT_W'(1);
        if (lat_last) begin
          if (win) m1_data_o <= s_data_i;
          else     m0_data_o <= s_data_i;
        end
      end
    end
  end

  assign s_rd_o     = (state == ST_ISSUE) & rd_q;
  assign s_we_o     = (state == ST_ISSUE) & we_q;
  assign gnt_o      = (state == ST_IDLE) ? 2'b00 : {win, ~win};
  assign m0_ready_o = (state == ST_DONE) & ~win;
  assign m1_ready_o = (state == ST_DONE) & win;

endmodule
